// File: rtl/aftab_booth_radix4_multiplier.sv
// Radix-4 Booth sequential multiplier with start/busy/done handshake and per-operand sign mode.
// Optional zero-operand shortcut enabled by defining AFTAB_BOOTH_ZERO_BYPASS_EN.
module aftab_booth_radix4_multiplier #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signedA,
   input  logic                 signedB,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   P
);

   localparam int unsigned N    = WIDTH + 2;
   localparam int unsigned ITER = N / 2;
   localparam int unsigned CW   = $clog2(ITER + 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e               r_state, w_state_d;
   logic [N-1:0]         r_m;
   logic [N:0]           r_q;
   logic [N+1:0]         r_h;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_p;

   logic                 w_accept, w_zero, w_last, w_neg;
   logic [N-1:0]         w_mx, w_qx;
   logic [N+1:0]         w_m_ext, w_sel, w_pp, w_sum, w_h_sh;
   logic [N:0]           w_q_sh;
   logic [2*WIDTH-1:0]   w_prod;

   assign busy     = (r_state == StCalc);
   assign done     = (r_state == StDone);
   assign P        = r_p;
   assign w_accept = start & ~busy;
   assign w_last   = (r_cnt == CW'(1));

   assign w_mx = {{2{signedA & A[WIDTH-1]}}, A};
   assign w_qx = {{2{signedB & B[WIDTH-1]}}, B};

`ifdef AFTAB_BOOTH_ZERO_BYPASS_EN
   assign w_zero = (A == '0) | (B == '0);
`else
   assign w_zero = 1'b0;
`endif

   // Booth recoding of Q[2:0]; negative multiples use one's complement plus carry-in.
   assign w_m_ext = {{2{r_m[N-1]}}, r_m};
   always_comb begin
      w_sel = '0;
      w_neg = 1'b0;
      case (r_q[2:0])
         3'b001, 3'b010: w_sel = w_m_ext;
         3'b011:         w_sel = w_m_ext << 1;
         3'b100: begin
            w_sel = w_m_ext << 1;
            w_neg = 1'b1;
         end
         3'b101, 3'b110: begin
            w_sel = w_m_ext;
            w_neg = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_pp   = w_neg ? ~w_sel : w_sel;
   assign w_sum  = r_h + w_pp + {{(N+1){1'b0}}, w_neg};
   assign w_h_sh = {{2{w_sum[N+1]}}, w_sum[N+1:2]};
   assign w_q_sh = {w_sum[1:0], r_q[N:2]};
   assign w_prod = {w_h_sh[2*WIDTH-N-1:0], w_q_sh[N:1]};

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle, StDone: begin
            if (start) w_state_d = w_zero ? StDone : StCalc;
            else       w_state_d = StIdle;
         end
         StCalc:  if (w_last) w_state_d = StDone;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_m     <= '0;
         r_q     <= '0;
         r_h     <= '0;
         r_cnt   <= '0;
         r_p     <= '0;
      end else begin
         r_state <= w_state_d;
         if (w_accept) begin
            r_m   <= w_mx;
            r_q   <= {w_qx, 1'b0};
            r_h   <= '0;
            r_cnt <= CW'(ITER);
            if (w_zero) r_p <= '0;
         end else if (r_state == StCalc) begin
            r_h   <= w_h_sh;
            r_q   <= w_q_sh;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) r_p <= w_prod;
         end
      end
   end

endmodule

// File: tb/tb_aftab_booth_radix4_multiplier.sv
// Self-checking bench: directed handshake/reset scenarios plus random operands against
// a plain-arithmetic product model.
module tb_aftab_booth_radix4_multiplier;

   localparam int ITER = 17;
`ifdef AFTAB_BOOTH_ZERO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, start, signedA, signedB;
   logic [31:0] A, B;
   logic        busy, done;
   logic [63:0] P;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   aftab_booth_radix4_multiplier #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .signedA (signedA),
      .signedB (signedB),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .P       (P)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb);
      logic signed [63:0] ax, bx;
      ax = sa ? $signed({{32{a[31]}}, a}) : $signed({32'b0, a});
      bx = sb ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
      return ax * bx;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) until done is seen at a falling edge; returns falling edges waited.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sa, input logic sb);
      logic [63:0] exp;
      bit          byp;
      int          n;
      exp = ref_mul(a, b, sa, sb);
      byp = BYP && (a == 0 || b == 0);
      @(negedge clk);
      A = a; B = b; signedA = sa; signedB = sb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = $urandom; B = $urandom; signedA = ~sa; signedB = ~sb;
      check({tag, "_busy"}, 64'(busy), byp ? 64'd0 : 64'd1);
      wait_done(n);
      // Cycles counted from the accept cycle: done in cycle ITER+1 (1 when bypassed).
      check({tag, "_lat"}, 64'(n + 1), byp ? 64'd1 : 64'(ITER + 1));
      check({tag, "_P"}, P, exp);
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_P_held"}, P, exp);
   endtask

   initial begin
      logic [63:0] exp1, exp2;
      logic [31:0] ra, rb;
      logic        rsa, rsb;
      int          n, ndone;

      rst = 1'b1; start = 1'b0; signedA = 1'b0; signedB = 1'b0; A = '0; B = '0;
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_P", P, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op("neg1_sq_signed", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
      check("neg1_sq_const", P, 64'h0000000000000001);
      run_op("max_sq_unsigned", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      check("max_sq_const", P, 64'hFFFFFFFE00000001);
      run_op("min_sq_signed", 32'h80000000, 32'h80000000, 1'b1, 1'b1);
      check("min_sq_const", P, 64'h4000000000000000);
      run_op("mixed_su", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
      check("mixed_su_const", P, 64'hFFFFFFFF00000001);
      run_op("mixed_us", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
      run_op("zero_a", 32'h0, 32'h5, 1'b0, 1'b0);
      run_op("zero_b", 32'h1234, 32'h0, 1'b1, 1'b1);

      // start during CALC must be ignored
      @(negedge clk);
      A = 32'd7; B = 32'd6; signedA = 1'b0; signedB = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      A = 32'd3; B = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      exp1  = '0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            exp1 = P;
         end
      end
      check("ignore_start_ndone", 64'(ndone), 64'd1);
      check("ignore_start_P", exp1, 64'd42);

      // back-to-back: start held across DONE
      exp1 = ref_mul(32'h00012345, 32'h00056789, 1'b0, 1'b0);
      exp2 = ref_mul(32'hFFFFFFFB, 32'h00000009, 1'b1, 1'b1);
      @(negedge clk);
      A = 32'h00012345; B = 32'h00056789; signedA = 1'b0; signedB = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      check("b2b_first_lat", 64'(n + 1), 64'(ITER + 1));
      check("b2b_first_P", P, exp1);
      A = 32'hFFFFFFFB; B = 32'h00000009; signedA = 1'b1; signedB = 1'b1; start = 1'b1;
      @(negedge clk);
      check("b2b_busy_rise", 64'(busy), 64'd1);
      start = 1'b0;
      wait_done(n);
      check("b2b_second_lat", 64'(n + 1), 64'(ITER + 1));
      check("b2b_second_P", P, exp2);

      // reset mid-CALC, with start asserted alongside
      @(negedge clk);
      A = 32'hDEADBEEF; B = 32'h0BADF00D; signedA = 1'b1; signedB = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1; start = 1'b1;
      #1;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_done", 64'(done), 64'd0);
      check("rst_mid_P", P, 64'd0);
      @(negedge clk);
      check("rst_wins_busy", 64'(busy), 64'd0);
      rst = 1'b0; start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      check("rst_no_done", 64'(ndone), 64'd0);
      run_op("post_rst", 32'h12345678, 32'h00000010, 1'b0, 1'b0);
      check("post_rst_const", P, 64'h0000000123456780);

      for (int i = 0; i < 24; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rsa = 1'($urandom);
         rsb = 1'($urandom);
         if (($urandom % 8) == 0) ra = '0;
         if (($urandom % 8) == 1) rb = '0;
         if (($urandom % 8) == 2) ra = {1'b1, 31'($urandom % 4)};
         run_op($sformatf("rand%0d", i), ra, rb, rsa, rsb);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/aftab_booth_radix4_multiplier.md
# aftab_booth_radix4_multiplier

Self-contained radix-4 (modified) Booth sequential multiplier for the AFTAB AAU. It generalises the radix-2 Booth datapath to a parameterised operand width, and adds an integrated controller, a start/busy/done handshake and per-operand signed/unsigned mode. It retires two multiplier bits per cycle, which covers all of RV32M `MUL`/`MULH`/`MULHSU`/`MULHU` with one unit.

## Interface
Parameters:
- `WIDTH`, 32, operand width. Must be even and ≥ 4. Internal extended width `N = WIDTH+2`; iteration count `ITER = N/2`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; accepted on a rising edge where `start=1` and `busy=0`.
- `signedA`  in  1  multiplicand `A` is two's-complement when 1, unsigned when 0.
- `signedB`  in  1  multiplier `B` is two's-complement when 1, unsigned when 0.
- `A`  in  WIDTH  multiplicand.
- `B`  in  WIDTH  multiplier.
- `busy`  out  1  high while in LOAD-consumed/CALC states; requests are ignored while high.
- `done`  out  1  one-cycle pulse; `P` is valid from this cycle.
- `P`  out  2*WIDTH  product; held until the next accepted request.

## Operation
- Operand extension at accept:
  - `Mx = {2{signedA & A[WIDTH-1]}, A}` (N bits).
  - `Qx = {2{signedB & B[WIDTH-1]}, B}` (N bits).
- Registers:
  - `M` (N bits) holds `Mx`.
  - `Q` (N+1 bits) loads `{Qx, 1'b0}`.
  - `H` (N+2 bits) accumulator.
  - Iteration counter: ceil(log2(ITER+1)) bits.
- Accept loads M, Q, clears H, loads the counter with ITER, and moves to CALC.
- Recoding in CALC, from `Q[2:0]`: 000/111 → 0; 001/010 → +M; 011 → +2M; 100 → −2M; 101/110 → −M.
  - M is sign-extended to N+2 bits before selection.
  - Subtraction uses add of the one's complement with carry-in 1.
- Per CALC cycle:
  - `S = H + pp`.
  - `{H, Q} ← {S, Q}` arithmetic-shifted right by 2; `S[N+1]` is replicated into the top two bits.
  - Counter decrements.
- Last iteration: when the counter reaches 1, the state goes to DONE and `P ← {H, Q[N:1]}[2*WIDTH-1:0]`, computed from the post-shift value.
- Result: the exact signed product of `Mx` and `Qx` truncated to 2*WIDTH bits. This is exact for all four sign modes.
- States:
  - IDLE: `busy=0`, `done=0`.
  - CALC: `busy=1`.
  - DONE: `busy=0`, `done=1`.
  - IDLE→CALC on accept.
  - CALC→CALC while counter > 1; CALC→DONE at counter = 1.
  - DONE→CALC on accept (back-to-back); otherwise DONE→IDLE.
- `start` while `busy=1` is ignored and has no effect on the operation in flight. Operand inputs are don't-care except at the accept edge.
- Operand changes after accept have no effect.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `P=0`; H, Q, M and counter are 0.
- Accept edge = edge 0. CALC occupies edges 1..ITER, so `busy=1` for ITER cycles.
- `done=1` during the cycle following edge ITER. Latency from accept to `done`: ITER+1 cycles (WIDTH=32: 18).
- Throughput: one result every ITER+1 cycles when `start` is held high.
- `rst` asserted mid-CALC: immediate return to IDLE, outputs as reset, no `done`. The first request after `rst` drops is accepted normally.
- `rst` and `start` in the same cycle: reset wins.

## Configuration
- `AFTAB_BOOTH_ZERO_BYPASS_EN` defined: if `A==0` or `B==0` at the accept edge, the unit skips CALC.
  - Next state is DONE with `P=0`, so `done` arrives in the cycle after accept.
  - `busy` stays 0 throughout.
- Macro undefined: every request takes the full ITER+1 cycles, including zero operands.

## Test plan
- WIDTH=32, both signed, `A=B=0xFFFFFFFF` (−1×−1) → `P=0x0000000000000001`, `done` 18 cycles after accept.
- Both unsigned, `A=B=0xFFFFFFFF` → `P=0xFFFFFFFE00000001`. Both signed, `A=B=0x80000000` → `P=0x4000000000000000`.
- Mixed: `signedA=1`, `signedB=0`, `A=0xFFFFFFFF`, `B=0xFFFFFFFF` → `P=0xFFFFFFFF00000001`.
- Request `A=7`, `B=6` (unsigned); pulse `start` with `A=3`, `B=3` at cycle 5 of CALC → `P=42` only, one `done` pulse. Hold `start` high across DONE → second op accepted that cycle and `busy` rises the next cycle.
- Assert `rst` at cycle 9 of CALC → `busy`/`done`/`P` go to 0 immediately. A fresh request `A=0x12345678`, `B=0x10` (unsigned) → `P=0x0000000123456780`.
- `A=0`, `B=0x5` (unsigned):
  - With `AFTAB_BOOTH_ZERO_BYPASS_EN` → `done` the cycle after accept, `P=0`.
  - Without it → `done` at 18 cycles, `P=0`.
